// File: rtl/rotl_iter.sv
// Iterative 16-bit rotate-left / shift-left-logical unit, one barrel stage per clock.
// Optional build macro ROTL_ITER_SKIP_EN: skip stages whose count bit is clear.
module rotl_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    input  logic        op,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [DW-1:0]   out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_q, op_d;
    logic            busy_d, done_d;

    // One barrel stage: move left by 2^sel, wrapping (ROL) or zero-filling (SLL).
    function automatic logic [DW-1:0] stage(input logic [DW-1:0] w,
                                            input logic [1:0]    sel,
                                            input logic          sll);
        logic [DW-1:0] r;
        case (sel)
            2'd0:    r = {w[14:0], (sll ? 1'b0  : w[15])};
            2'd1:    r = {w[13:0], (sll ? 2'b0  : w[15:14])};
            2'd2:    r = {w[11:0], (sll ? 4'b0  : w[15:12])};
            default: r = {w[7:0],  (sll ? 8'b0  : w[15:8])};
        endcase
        return r;
    endfunction

`ifdef ROTL_ITER_SKIP_EN
    // Index of the lowest pending count bit; cnt_q doubles as the remaining-stage mask.
    function automatic logic [1:0] low_idx(input logic [CW-1:0] m);
        logic [1:0] r;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    logic [1:0]    sel_c;
    logic [CW-1:0] rem_c;

    assign sel_c = low_idx(cnt_q);
    assign rem_c = cnt_q & ~(CW'(1) << sel_c);
`else
    logic [1:0] k, k_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            out   <= '0;
            cnt_q <= '0;
            op_q  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifndef ROTL_ITER_SKIP_EN
            k     <= 2'd0;
`endif
        end else begin
            state <= state_d;
            out   <= out_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
            busy  <= busy_d;
            done  <= done_d;
`ifndef ROTL_ITER_SKIP_EN
            k     <= k_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        out_d   = out;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = busy;
        done_d  = 1'b0;
`ifndef ROTL_ITER_SKIP_EN
        k_d     = k;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    out_d   = in;
                    cnt_d   = cnt;
                    op_d    = op;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifndef ROTL_ITER_SKIP_EN
                    k_d     = 2'd0;
`endif
                end
            end
            default: begin
`ifdef ROTL_ITER_SKIP_EN
                if (|cnt_q) begin
                    out_d = stage(out, sel_c, op_q);
                end
                cnt_d = rem_c;
                if (rem_c == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
`else
                if (cnt_q[k]) begin
                    out_d = stage(out, k, op_q);
                end
                if (k == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d = k + 2'd1;
                end
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_rotl_iter.sv
// Directed bench for rotl_iter: vector table plus handshake, back-to-back and reset sequences.
module tb_rotl_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        op;
    logic [15:0] dout;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    rotl_iter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in   (din),
        .cnt  (cnt),
        .op   (op),
        .out  (dout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef ROTL_ITER_SKIP_EN
        int n;
        n = 32'(c[0]) + 32'(c[1]) + 32'(c[2]) + 32'(c[3]);
        return (n == 0) ? 1 : n;
`else
        return 4;
`endif
    endfunction

    // Waits (bounded) for done; lat = number of edges seen, 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic accept(input logic o, input logic [15:0] d, input logic [3:0] c);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        cnt   = c;
        op    = o;
        @(posedge clk);
        #1;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        din   = 16'h5A5A;
        cnt   = 4'($urandom_range(0, 15));
        op    = ~o;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [15:0] held;
        accept(v.op, v.din, v.cnt);
        wait_done(lat);
        check("latency", 32'(lat), 32'(exp_lat(v.cnt)));
        check("result", 32'(dout), 32'(v.exp));
        check("busy_at_done", 32'(busy), 32'd0);
        held = dout;
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("out_held", 32'(dout), 32'(held));
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        int ndone;

        vecs[0]  = '{1'b0, 16'h8001, 4'd1,  16'h0003};
        vecs[1]  = '{1'b0, 16'h1234, 4'd4,  16'h2341};
        vecs[2]  = '{1'b1, 16'h1234, 4'd4,  16'h2340};
        vecs[3]  = '{1'b0, 16'hF00F, 4'd15, 16'hF807};
        vecs[4]  = '{1'b1, 16'hFFFF, 4'd15, 16'h8000};
        vecs[5]  = '{1'b0, 16'hBEEF, 4'd0,  16'hBEEF};
        vecs[6]  = '{1'b1, 16'hBEEF, 4'd0,  16'hBEEF};
        vecs[7]  = '{1'b0, 16'h1234, 4'd10, 16'hD048};
        vecs[8]  = '{1'b1, 16'h1234, 4'd10, 16'hD000};
        vecs[9]  = '{1'b1, 16'h0001, 4'd15, 16'h8000};
        vecs[10] = '{1'b1, 16'hA5A5, 4'd3,  16'h2D28};

        rst   = 1'b0;
        start = 1'b0;
        din   = '0;
        cnt   = '0;
        op    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(dout), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start while busy is ignored; first result intact
        accept(1'b0, 16'h1234, 4'd15);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        din   = 16'h0001;
        cnt   = 4'd0;
        op    = 1'b1;
        @(posedge clk);
        #1;
        check("ignored_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ignored_latency", 32'(lat + 2), 32'd4);
        check("ignored_result", 32'(dout), 32'h091A);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("ignored_not_queued", 32'(ndone), 32'd0);

        // back-to-back accept in the done cycle
        accept(1'b0, 16'h8001, 4'd1);
        wait_done(lat);
        check("b2b_first_result", 32'(dout), 32'h0003);
        @(negedge clk);
        start = 1'b1;
        din   = 16'hBEEF;
        cnt   = 4'd4;
        op    = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_done_cleared", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'(exp_lat(4'd4)));
        check("b2b_second_result", 32'(dout), 32'hEEF0);

        // reset mid-run aborts with no done
        accept(1'b0, 16'h1234, 4'd15);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out", 32'(dout), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_out_idle", 32'(dout), 32'h0);
        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
